collision_tracker: RTL and testbench

Parametrised successor to the single-flag Pong collision detector. Counts per-source pixel overlap between the ball and up to NUM_PADDLES paddles and NUM_WALLS walls during each active frame. Qualifies each hit against a minimum overlap threshold and records the screen coordinates of the first qualified contact. Publishes a per-frame collision report to the ball-motion controller through a valid/ack handshake.

---
 rtl/collision_tracker_if.sv | 40 ++++
 rtl/collision_tracker.sv | 180 ++++++++++++++++++
 tb/tb_collision_tracker.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_tracker_if.sv
// rtl/collision_tracker_if.sv - collision report channel; COLL_PRIORITY_EN adds coll_first_id
interface collision_tracker_if #(
   parameter int NUM_PADDLES = 2,
   parameter int NUM_WALLS   = 4,
   parameter int CNT_W       = 10
);
`ifdef COLL_PRIORITY_EN
   localparam int ID_W = $clog2(NUM_PADDLES + NUM_WALLS);
`endif

   logic                   coll_valid;
   logic                   coll_ack;
   logic [NUM_PADDLES-1:0] coll_paddle;
   logic [NUM_WALLS-1:0]   coll_wall;
   logic [CNT_W-1:0]       coll_x;
   logic [CNT_W-1:0]       coll_y;
`ifdef COLL_PRIORITY_EN
   logic [ID_W-1:0]        coll_first_id;
`endif

`ifdef COLL_PRIORITY_EN
   modport master (
      output coll_valid, coll_paddle, coll_wall, coll_x, coll_y, coll_first_id,
      input  coll_ack
   );
   modport slave (
      input  coll_valid, coll_paddle, coll_wall, coll_x, coll_y, coll_first_id,
      output coll_ack
   );
`else
   modport master (
      output coll_valid, coll_paddle, coll_wall, coll_x, coll_y,
      input  coll_ack
   );
   modport slave (
      input  coll_valid, coll_paddle, coll_wall, coll_x, coll_y,
      output coll_ack
   );
`endif
endinterface

// File: rtl/collision_tracker.sv
// rtl/collision_tracker.sv - per-frame ball/paddle/wall overlap tracker; optional COLL_PRIORITY_EN
module collision_tracker #(
   parameter int NUM_PADDLES = 2,
   parameter int NUM_WALLS   = 4,
   parameter int CNT_W       = 10,
   parameter int MIN_HITS    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ball_sig,
   input  logic [NUM_PADDLES-1:0] paddle_sig,
   input  logic [NUM_WALLS-1:0]   wall_sig,
   input  logic [CNT_W-1:0]       hcount,
   input  logic [CNT_W-1:0]       vcount,
   input  logic                   vsync,
   collision_tracker_if.master    coll,
   output logic                   overrun
);

   localparam int         NUM_SRC    = NUM_PADDLES + NUM_WALLS;
   localparam logic [7:0] MIN_HITS_C = 8'(MIN_HITS);
`ifdef COLL_PRIORITY_EN
   localparam int         ID_W       = $clog2(NUM_SRC);
`endif

   typedef enum logic {
      SCAN      = 1'b0,
      FRAME_END = 1'b1
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic                 vsync_q;
   logic                 publish;

   // Paddles occupy the low source indices, walls follow.
   logic [NUM_SRC-1:0]   src_sig;
   logic [NUM_SRC-1:0]   count_en;
   logic [NUM_SRC-1:0]   qualified;
   logic [NUM_SRC-1:0]   new_qual;
   logic [7:0]           cnt_q [NUM_SRC];

   logic                 first_q;
   logic [CNT_W-1:0]     pending_x_q;
   logic [CNT_W-1:0]     pending_y_q;
`ifdef COLL_PRIORITY_EN
   logic [ID_W-1:0]      first_id_q;
   logic [ID_W-1:0]      first_hit_id;
`endif

   assign src_sig = {wall_sig, paddle_sig};

   // State register and vsync history for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SCAN;
         vsync_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vsync_q <= vsync;
      end
   end

   // Frame end is the first cycle vsync is seen low after being high.
   always_comb begin
      state_d = SCAN;
      publish = 1'b0;
      case (state_q)
         SCAN: begin
            if (vsync_q && !vsync) begin
               publish = 1'b1;
               state_d = FRAME_END;
            end
         end
         FRAME_END: state_d = SCAN;
         default:   state_d = SCAN;
      endcase
   end

   // Per-source overlap enables; a counter stops once it reaches MIN_HITS.
   always_comb begin
      qualified = '0;
      count_en  = '0;
      new_qual  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         qualified[i] = (cnt_q[i] == MIN_HITS_C);
         count_en[i]  = vsync && ball_sig && src_sig[i] && !qualified[i];
         new_qual[i]  = count_en[i] && (cnt_q[i] == MIN_HITS_C - 8'd1);
      end
   end

`ifdef COLL_PRIORITY_EN
   // Lowest-index source among those qualifying this cycle.
   always_comb begin
      first_hit_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (new_qual[i]) begin
            first_hit_id = ID_W'(i);
         end
      end
   end
`endif

   // Overlap counters, cleared when the frame report is published.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            cnt_q[i] <= 8'd0;
         end
      end else if (publish) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            cnt_q[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (count_en[i]) begin
               cnt_q[i] <= cnt_q[i] + 8'd1;
            end
         end
      end
   end

   // Latch the coordinates of the first qualifying pixel of the frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_q     <= 1'b0;
         pending_x_q <= '0;
         pending_y_q <= '0;
`ifdef COLL_PRIORITY_EN
         first_id_q  <= '0;
`endif
      end else if (publish) begin
         first_q     <= 1'b0;
         pending_x_q <= '0;
         pending_y_q <= '0;
`ifdef COLL_PRIORITY_EN
         first_id_q  <= '0;
`endif
      end else if (!first_q && (|new_qual)) begin
         first_q     <= 1'b1;
         pending_x_q <= hcount;
         pending_y_q <= vcount;
`ifdef COLL_PRIORITY_EN
         first_id_q  <= first_hit_id;
`endif
      end
   end

   // Report registers and valid/ack handshake; a hit-free frame leaves them alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coll.coll_valid    <= 1'b0;
         coll.coll_paddle   <= '0;
         coll.coll_wall     <= '0;
         coll.coll_x        <= '0;
         coll.coll_y        <= '0;
`ifdef COLL_PRIORITY_EN
         coll.coll_first_id <= '0;
`endif
         overrun            <= 1'b0;
      end else if (publish && (|qualified)) begin
         coll.coll_valid    <= 1'b1;
         coll.coll_paddle   <= qualified[NUM_PADDLES-1:0];
         coll.coll_wall     <= qualified[NUM_SRC-1:NUM_PADDLES];
         coll.coll_x        <= pending_x_q;
         coll.coll_y        <= pending_y_q;
`ifdef COLL_PRIORITY_EN
         coll.coll_first_id <= first_id_q;
`endif
         // Overwriting an unacked report flags overrun; an ack on this edge consumes the old one.
         if (coll.coll_valid) begin
            overrun <= !coll.coll_ack;
         end
      end else if (coll.coll_valid && coll.coll_ack) begin
         coll.coll_valid <= 1'b0;
         overrun         <= 1'b0;
      end
   end

endmodule

// File: tb/tb_collision_tracker.sv
// tb/tb_collision_tracker.sv - scoreboard bench for collision_tracker (MIN_HITS 1 and 3)
module tb_collision_tracker;

   logic       clk = 1'b0;
   logic       rst;
   logic       ball;
   logic [1:0] paddle;
   logic [3:0] wall;
   logic [9:0] hc;
   logic [9:0] vc;
   logic       vsync;
   logic       ack;
   logic       o1;
   logic       o3;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       valid;
      logic [1:0] paddle;
      logic [3:0] wall;
      logic [9:0] x;
      logic [9:0] y;
      logic       ovr;
      logic [2:0] fid;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];

   collision_tracker_if #(.NUM_PADDLES(2), .NUM_WALLS(4), .CNT_W(10)) if1 ();
   collision_tracker_if #(.NUM_PADDLES(2), .NUM_WALLS(4), .CNT_W(10)) if3 ();
   assign if1.coll_ack = ack;
   assign if3.coll_ack = ack;

   collision_tracker #(.NUM_PADDLES(2), .NUM_WALLS(4), .CNT_W(10), .MIN_HITS(1)) dut1 (
      .clk(clk), .rst(rst), .ball_sig(ball), .paddle_sig(paddle), .wall_sig(wall),
      .hcount(hc), .vcount(vc), .vsync(vsync), .coll(if1), .overrun(o1)
   );

   collision_tracker #(.NUM_PADDLES(2), .NUM_WALLS(4), .CNT_W(10), .MIN_HITS(3)) dut3 (
      .clk(clk), .rst(rst), .ball_sig(ball), .paddle_sig(paddle), .wall_sig(wall),
      .hcount(hc), .vcount(vc), .vsync(vsync), .coll(if3), .overrun(o3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic v, input logic [1:0] p, input logic [3:0] w,
                               input int x, input int y, input logic o, input int f);
      exp_t e;
      e.valid  = v;
      e.paddle = p;
      e.wall   = w;
      e.x      = 10'(x);
      e.y      = 10'(y);
      e.ovr    = o;
      e.fid    = 3'(f);
      return e;
   endfunction

   task automatic cmp_rep(input string tag, input exp_t e, input logic v, input logic [1:0] p,
                          input logic [3:0] w, input logic [9:0] x, input logic [9:0] y,
                          input logic o, input logic [2:0] f);
      chk({tag, ".valid"},   32'(v), 32'(e.valid));
      chk({tag, ".paddle"},  32'(p), 32'(e.paddle));
      chk({tag, ".wall"},    32'(w), 32'(e.wall));
      chk({tag, ".x"},       32'(x), 32'(e.x));
      chk({tag, ".y"},       32'(y), 32'(e.y));
      chk({tag, ".overrun"}, 32'(o), 32'(e.ovr));
`ifdef COLL_PRIORITY_EN
      chk({tag, ".first_id"}, 32'(f), 32'(e.fid));
`else
      if (f !== 3'd0) begin
         $display("note: unused first_id argument %0d", f);
      end
`endif
   endtask

   // Monitor: tracks frame-end edges independently and checks each published report.
   logic mon_vq;
   logic mon_fe;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mon_vq <= 1'b0;
         mon_fe <= 1'b0;
      end else begin
         mon_fe <= mon_vq && !vsync;
         mon_vq <= vsync;
      end
   end

   always @(negedge clk) begin
      if (mon_fe && !rst) begin
         exp_t e;
         logic [2:0] f1;
         logic [2:0] f3;
`ifdef COLL_PRIORITY_EN
         f1 = if1.coll_first_id;
         f3 = if3.coll_first_id;
`else
         f1 = 3'd0;
         f3 = 3'd0;
`endif
         n_tests++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL d1.scoreboard: got empty queue expected an entry at %0t", $time);
         end else begin
            e = q1.pop_front();
            cmp_rep("d1", e, if1.coll_valid, if1.coll_paddle, if1.coll_wall,
                    if1.coll_x, if1.coll_y, o1, f1);
         end
         n_tests++;
         if (q3.size() == 0) begin
            n_fail++;
            $display("FAIL d3.scoreboard: got empty queue expected an entry at %0t", $time);
         end else begin
            e = q3.pop_front();
            cmp_rep("d3", e, if3.coll_valid, if3.coll_paddle, if3.coll_wall,
                    if3.coll_x, if3.coll_y, o3, f3);
         end
      end
   end

   task automatic pix(input logic b, input logic [1:0] p, input logic [3:0] w, input int h, input int v);
      @(negedge clk);
      ball   = b;
      paddle = p;
      wall   = w;
      hc     = 10'(h);
      vc     = 10'(v);
      vsync  = 1'b1;
   endtask

   task automatic frame_end(input logic with_ack);
      @(negedge clk);
      ball   = 1'b0;
      paddle = '0;
      wall   = '0;
      vsync  = 1'b0;
      ack    = with_ack;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vsync = 1'b1;
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("ack.d1.valid", 32'(if1.coll_valid), 32'd0);
      chk("ack.d3.valid", 32'(if3.coll_valid), 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".d1.valid"},  32'(if1.coll_valid),  32'd0);
      chk({tag, ".d1.paddle"}, 32'(if1.coll_paddle), 32'd0);
      chk({tag, ".d1.wall"},   32'(if1.coll_wall),   32'd0);
      chk({tag, ".d1.x"},      32'(if1.coll_x),      32'd0);
      chk({tag, ".d1.y"},      32'(if1.coll_y),      32'd0);
      chk({tag, ".d1.ovr"},    32'(o1),              32'd0);
      chk({tag, ".d3.valid"},  32'(if3.coll_valid),  32'd0);
      chk({tag, ".d3.x"},      32'(if3.coll_x),      32'd0);
      chk({tag, ".d3.ovr"},    32'(o3),              32'd0);
`ifdef COLL_PRIORITY_EN
      chk({tag, ".d1.fid"},    32'(if1.coll_first_id), 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      ball   = 1'b0;
      paddle = '0;
      wall   = '0;
      hc     = '0;
      vc     = '0;
      vsync  = 1'b1;
      ack    = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      // Frame A: single paddle-1 overlap; a paddle pixel without ball does not count.
      pix(1'b0, 2'b01, 4'b0000, 100, 100);
      pix(1'b1, 2'b10, 4'b0000, 600, 200);
      pix(1'b1, 2'b00, 4'b0000, 601, 200);
      q1.push_back(mk(1'b1, 2'b10, 4'b0000, 600, 200, 1'b0, 1));
      q3.push_back(mk(1'b0, 2'b00, 4'b0000, 0, 0, 1'b0, 0));
      frame_end(1'b0);
      do_ack();

      // Frame B: wall0 three pixels, paddle0 two pixels.
      pix(1'b1, 2'b00, 4'b0001, 318, 0);
      pix(1'b1, 2'b00, 4'b0001, 319, 0);
      pix(1'b1, 2'b00, 4'b0001, 320, 0);
      pix(1'b1, 2'b01, 4'b0000, 100, 5);
      pix(1'b1, 2'b01, 4'b0000, 101, 5);
      q1.push_back(mk(1'b1, 2'b01, 4'b0001, 318, 0, 1'b0, 2));
      q3.push_back(mk(1'b1, 2'b00, 4'b0001, 320, 0, 1'b0, 2));
      frame_end(1'b0);
      do_ack();

      // Frame C: no overlap; valid stays low and data holds.
      pix(1'b1, 2'b00, 4'b0000, 50, 50);
      pix(1'b0, 2'b11, 4'b1111, 60, 60);
      q1.push_back(mk(1'b0, 2'b01, 4'b0001, 318, 0, 1'b0, 2));
      q3.push_back(mk(1'b0, 2'b00, 4'b0001, 320, 0, 1'b0, 2));
      frame_end(1'b0);

      // Frame D: paddle1 and wall3 together; left unacked.
      pix(1'b1, 2'b10, 4'b1000, 400, 300);
      pix(1'b1, 2'b10, 4'b1000, 401, 300);
      pix(1'b1, 2'b10, 4'b1000, 402, 300);
      q1.push_back(mk(1'b1, 2'b10, 4'b1000, 400, 300, 1'b0, 1));
      q3.push_back(mk(1'b1, 2'b10, 4'b1000, 402, 300, 1'b0, 1));
      frame_end(1'b0);

      // Frame E: overwrite without ack sets overrun; fourth pixel exercises saturation.
      pix(1'b1, 2'b00, 4'b0010, 10, 479);
      pix(1'b1, 2'b00, 4'b0010, 11, 479);
      pix(1'b1, 2'b00, 4'b0010, 12, 479);
      pix(1'b1, 2'b00, 4'b0010, 13, 479);
      q1.push_back(mk(1'b1, 2'b00, 4'b0010, 10, 479, 1'b1, 3));
      q3.push_back(mk(1'b1, 2'b00, 4'b0010, 12, 479, 1'b1, 3));
      frame_end(1'b0);

      // Frame F: ack coincides with the publish edge.
      pix(1'b1, 2'b01, 4'b0000, 200, 100);
      pix(1'b1, 2'b01, 4'b0000, 201, 100);
      pix(1'b1, 2'b01, 4'b0000, 202, 100);
      q1.push_back(mk(1'b1, 2'b01, 4'b0000, 200, 100, 1'b0, 0));
      q3.push_back(mk(1'b1, 2'b01, 4'b0000, 202, 100, 1'b0, 0));
      frame_end(1'b1);

      // Frame G: partial counts, then an asynchronous reset mid-cycle.
      pix(1'b1, 2'b01, 4'b0000, 300, 50);
      pix(1'b1, 2'b01, 4'b0000, 301, 50);
      @(negedge clk);
      ball = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      pix(1'b1, 2'b01, 4'b0000, 302, 50);
      q1.push_back(mk(1'b1, 2'b01, 4'b0000, 302, 50, 1'b0, 0));
      q3.push_back(mk(1'b0, 2'b00, 4'b0000, 0, 0, 1'b0, 0));
      frame_end(1'b0);
      repeat (2) @(negedge clk);

      chk("scoreboard.d1.drained", 32'(q1.size()), 32'd0);
      chk("scoreboard.d3.drained", 32'(q3.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
